// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and data_mem: sign extension,
// misaligned-access splitting, bounds checking and one response per request.
module lsu_ctrl #(
    parameter int unsigned MEM_WORDS     = 256,
    parameter bit          MISALIGN_TRAP = 1'b0
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_dataW,
    output logic        mem_MEMRW,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_dataR
);
    typedef enum logic [2:0] {IDLE, ACC, LD_HI, ST_B, RESP} state_t;

    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
    localparam logic [2:0]  F3_WORD   = 3'b010;

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] mem_adr_q, mem_adr_d;
    logic [31:0] mem_dataW_q, mem_dataW_d;
    logic        mem_MEMRW_q, mem_MEMRW_d;
    logic [2:0]  mem_func3_q, mem_func3_d;
    logic        we_q, we_d;
    logic [2:0]  func3_q, func3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mis_q, mis_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] lo_q, lo_d;

    logic [2:0]  req_size;
    logic [32:0] req_last;
    logic        req_mis;
    logic        req_bad;
    logic [1:0]  idx_nxt;
    logic [63:0] ld_pair;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend = {24'd0, raw[7:0]};
            3'b101:  extend = {16'd0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // The 33-bit last-byte sum makes an address wrap look out of range too.
    always_comb begin
        case (req_func3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        req_last = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
        req_mis  = (req_func3[1:0] == 2'b01 && req_addr[0]) ||
                   (req_func3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
        req_bad  = (req_func3 == 3'b011) || (req_func3[2:1] == 2'b11) ||
                   (req_we && req_func3[2]) || (req_last >= MEM_BYTES) ||
                   (req_mis && MISALIGN_TRAP);
    end

    assign idx_nxt = idx_q + 2'd1;
    assign ld_pair = {mem_dataR, lo_q} >> {addr_q[1:0], 3'b000};

    always_comb begin
        state_d     = state_q;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        mem_adr_d   = '0;
        mem_dataW_d = '0;
        mem_MEMRW_d = 1'b0;
        mem_func3_d = F3_WORD;
        we_d        = we_q;
        func3_d     = func3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mis_d       = mis_q;
        size_d      = size_q;
        idx_d       = idx_q;
        lo_d        = lo_q;
        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    we_d        = req_we;
                    func3_d     = req_func3;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    mis_d       = req_mis;
                    size_d      = req_size;
                    idx_d       = 2'd0;
                    if (req_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_mis && req_we) begin
                        state_d     = ST_B;
                        mem_adr_d   = req_addr;
                        mem_func3_d = 3'b000;
                        mem_dataW_d = {24'd0, req_wdata[7:0]};
                        mem_MEMRW_d = 1'b1;
                    end else if (req_mis) begin
                        state_d   = ACC;
                        mem_adr_d = {req_addr[31:2], 2'b00};
                    end else begin
                        state_d     = ACC;
                        mem_adr_d   = req_addr;
                        mem_func3_d = {1'b0, req_func3[1:0]};
                        mem_dataW_d = req_wdata;
                        mem_MEMRW_d = req_we;
                    end
                end
            end
            ACC: begin
                if (mis_q) begin
                    lo_d      = mem_dataR;
                    state_d   = LD_HI;
                    mem_adr_d = {addr_q[31:2], 2'b00} + 32'd4;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (!we_q) rsp_rdata_d = extend(mem_dataR, func3_q);
                end
            end
            LD_HI: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extend(ld_pair[31:0], func3_q);
            end
            // Split stores write one byte per cycle, never read-modify-write.
            ST_B: begin
                if ({1'b0, idx_q} == size_q - 3'd1) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    idx_d       = idx_nxt;
                    mem_adr_d   = addr_q + {30'd0, idx_nxt};
                    mem_func3_d = 3'b000;
                    mem_dataW_d = {24'd0, wdata_q[{idx_nxt, 3'b000} +: 8]};
                    mem_MEMRW_d = 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_adr_q   <= '0;
            mem_dataW_q <= '0;
            mem_MEMRW_q <= 1'b0;
            mem_func3_q <= F3_WORD;
            we_q        <= 1'b0;
            func3_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            size_q      <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_adr_q   <= mem_adr_d;
            mem_dataW_q <= mem_dataW_d;
            mem_MEMRW_q <= mem_MEMRW_d;
            mem_func3_q <= mem_func3_d;
            we_q        <= we_d;
            func3_q     <= func3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mis_q       <= mis_d;
            size_q      <= size_d;
            idx_q       <= idx_d;
            lo_q        <= lo_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_adr   = mem_adr_q;
    assign mem_dataW = mem_dataW_q;
    assign mem_MEMRW = mem_MEMRW_q;
    assign mem_func3 = mem_func3_q;
endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the execute stage and data_mem.
- Accepts one load or store per handshake and drives data_mem's adr/dataW/MEMRW/func3 port. It reads data_mem's zero-extended, word-local dataR.
- Adds RV32 sign extension, splits misaligned accesses into legal data_mem accesses, checks bounds, and returns one response per request.

Parameters:
- MEM_WORDS, 256, number of implemented 32-bit words; byte addresses at or above MEM_WORDS*4 are out of range.
- MISALIGN_TRAP, 0, 1 = misaligned access returns error with no memory access; 0 = split the access.

Ports:
- cpu_clk  in  1  clock
- cpu_rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_func3  in  3  RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB/SH/SW 000/001/010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  error qualifier, valid with rsp_valid
- mem_adr  out  32  to data_mem adr
- mem_dataW  out  32  to data_mem dataW
- mem_MEMRW  out  1  to data_mem MEMRW (1 = write)
- mem_func3  out  3  to data_mem func3 (only 000/001/010 driven)
- mem_dataR  in  32  from data_mem dataR (combinational)

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_adr=0, mem_dataW=0, mem_MEMRW=0, mem_func3=010.
- The same mem_* idle values are driven in every non-access state. mem_MEMRW is 1 only in store-access states.
- States: IDLE, ACC, LD_HI, ST_B, RESP. req_ready=1 only in IDLE.
- Request is registered on acceptance in IDLE. Size = 1/2/4 bytes from func3[1:0].
- Illegal request, RESP with rsp_err=1, no memory access. Illegal means any of:
  - func3 011, 110 or 111;
  - store with func3[2]=1;
  - last byte (addr+size-1, computed in 33 bits) >= MEM_WORDS*4, which also catches address wrap;
  - misaligned with MISALIGN_TRAP=1.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=00.
- Aligned access, ACC (1 cycle):
  - mem_adr=addr, mem_func3={1'b0,func3[1:0]}, mem_dataW=wdata, MEMRW=we.
  - Loads capture mem_dataR at the end of ACC.
  - Stores commit at the ACC clock edge.
- Misaligned load:
  - ACC reads word addr&~3 with func3 010 and captures it as lo.
  - LD_HI reads word (addr&~3)+4 with func3 010 and captures it as hi.
  - Result = ({hi,lo} >> 8*addr[1:0]), truncated to size.
- Misaligned store:
  - ST_B runs size cycles (2 or 4). Cycle i drives adr=addr+i, func3 000, dataW[7:0]=wdata[8i+7:8i], MEMRW=1.
  - Memory is not read-modify-written.
- Load extension:
  - aligned LB/LH: pick byte/half of mem_dataR by addr (data_mem already positions it in bits [7:0]/[15:0]);
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU/LW: no extension.
- RESP (1 cycle): rsp_valid=1 with rsp_rdata/rsp_err, then IDLE. rsp_* outputs are 0 outside RESP.
- Latency, acceptance edge to rsp_valid:
  - aligned: 2 cycles;
  - misaligned load: 3 cycles;
  - misaligned store: size+1 cycles;
  - error: 1 cycle.
- Back-to-back: the next request is accepted in the IDLE cycle after RESP. There is no response backpressure.
- Reset mid-operation: returns to IDLE immediately with MEMRW=0 and no response. Bytes of a split store already committed remain written.

Test Plan:
- SW 0x100 ← 0xDEADBEEF, then LW 0x100 → mem writes at ACC edge; load rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, err=0.
- With word 0x100=0x80FF7F01: LB 0x103 → 0xFFFFFF80; LBU 0x103 → 0x00000080; LH 0x102 → 0xFFFF80FF; LHU 0x100 → 0x00007F01.
- Words 0x100=0x44332211 and 0x104=0x88776655, LW 0x101 → two reads (0x100, 0x104), rsp_rdata=0x55443322 at 3 cycles.
- SW 0x103 ← 0xA1B2C3D4, then LW 0x100/0x104 → 4 byte writes at 0x103..0x106, words read 0xD4xxxxxx / 0xxxA1B2C3 (untouched bytes preserved). With MISALIGN_TRAP=1 → rsp_err=1, MEMRW never asserted.
- LW 0x3FC (MEM_WORDS=256) → normal access; LW 0x3FD (split) and LW 0xFFFFFFFE → rsp_err=1 one cycle after accept, rdata=0, no access. func3 011 → err.
- Assert cpu_rst_n low during the 2nd byte of a split SH/SW → MEMRW=0 immediately, no rsp_valid, req_ready=1 after release, first byte remains in memory.
